// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that merges N_REQ valid/ready writers
// onto the single write port of a FIFO.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    fifo_wr,
    output logic [DATA_W-1:0]       fifo_data_in,
    input  logic                    fifo_full,
    output logic                    grant_valid,
    output logic [1:0]              grant_id
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t     state;
    logic [1:0] last_id;
    logic [3:0] cnt;
    logic       busy;
    logic       owner_valid;
    logic       burst_end;
    logic       rearb;
    logic       found;
    logic [1:0] pick;
    logic [1:0] cand;

    assign busy        = (state == BURST);
    assign owner_valid = req_valid[grant_id];
    assign grant_valid = busy;
    assign fifo_wr     = busy && owner_valid && !fifo_full;

    assign fifo_data_in = busy ? req_data[grant_id*DATA_W +: DATA_W]
                               : '0;

    always_comb begin
        req_ready = '0;
        if (busy && !fifo_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // A full stall freezes the burst; it never ends it.
    assign burst_end = busy && !fifo_full &&
                       (!owner_valid || cnt == LAST_BEAT);
    assign rearb     = !busy || burst_end;

    // Search starts after the last owner, so it is visited last.
    always_comb begin
        found = 1'b0;
        pick  = last_id;
        cand  = last_id;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last_id + 2'(k);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            last_id  <= 2'(N_REQ - 1);
            cnt      <= '0;
        end else begin
            if (fifo_wr) begin
                cnt <= cnt + 4'd1;
            end
            if (rearb) begin
                cnt <= '0;
                if (found) begin
                    state    <= BURST;
                    grant_id <= pick;
                    last_id  <= pick;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of write requesters (fixed at 4 for this release).
REQ-002 SHALL have parameter DATA_W, default 8: data width, matching FIFO_Memory data_in.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum consecutive beats per grant (range 1..15).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, N_REQ bits: requester i holds a beat.
REQ-007 SHALL have port req_data, input, N_REQ*DATA_W bits: requester i data in bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_ready, output, N_REQ bits: beat i accepted at this edge when req_valid[i]&&req_ready[i].
REQ-009 SHALL have port fifo_wr, output, 1 bit: drives FIFO_Memory wr.
REQ-010 SHALL have port fifo_data_in, output, DATA_W bits: drives FIFO_Memory data_in.
REQ-011 SHALL have port fifo_full, input, 1 bit: from FIFO_Memory fifo_full.
REQ-012 SHALL have port grant_valid, output, 1 bit: a requester currently owns the write port.
REQ-013 SHALL have port grant_id, output, 2 bits: index of the current owner.

Function
REQ-014 SHALL implement FSM states IDLE (no owner) and BURST (owner = grant_id); grant_valid=1 exactly in BURST.
REQ-015 SHALL drive fifo_wr = BURST && req_valid[grant_id] && !fifo_full, combinationally, and never assert it while fifo_full=1.
REQ-016 SHALL drive req_ready[i] = (i==grant_id) && BURST && !fifo_full, and fifo_data_in = req_data slice of grant_id (0 when IDLE).
REQ-017 SHALL keep a beat counter (4 bits), cleared on every new grant and incremented by 1 on each cycle with fifo_wr=1.
REQ-018 SHALL release the grant at an edge in BURST when req_valid[grant_id]=0, or when fifo_wr=1 and the counter equals MAX_BURST-1.
REQ-019 SHALL re-arbitrate at the edge of release (or at any edge in IDLE): round-robin search starting at last owner+1 mod N_REQ over the req_valid sampled at that edge; a match -> BURST with the new owner, no match -> IDLE.
REQ-020 SHALL allow the releasing owner to be regranted only if no other requester is valid; its counter restarts at 0.
REQ-021 SHALL hold the grant, counter and fifo_data_in selection unchanged while fifo_full=1; a full stall never causes release.
REQ-022 SHALL have a one-cycle grant latency from IDLE (valid seen at edge k; first write at edge k+1) and no bubble between back-to-back bursts released by MAX_BURST.
REQ-023 SHALL preserve per-requester beat order; beats are never duplicated or dropped.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE, grant_valid=0, grant_id=0, counter=0, fifo_wr=0, req_ready=0, fifo_data_in=0, asynchronously.
REQ-025 SHALL set the last-owner pointer to N_REQ-1 on reset, so requester 0 has first priority.
REQ-026 SHALL drop fifo_wr within the same cycle when rst_n falls mid-burst; no partial state is retained.

Verification
REQ-027 SHALL pass: reset release, req_valid=0001, data 0x11 -> grant_valid=1, grant_id=0 at edge 1; fifo_wr=1 in that cycle; 0x11 written at edge 2.
REQ-028 SHALL pass: all four requesters valid continuously, FIFO never full, MAX_BURST=4 -> write order of 4 beats each from 0,1,2,3,0, with zero idle cycles.
REQ-029 SHALL pass: fifo_full forced high for 3 cycles after beat 2 of requester 1 -> fifo_wr=0, req_ready=0, grant_id=1, counter=2 held; beats 3-4 follow once full clears.
REQ-030 SHALL pass: requester 2 drops valid after 2 beats while requester 3 is valid -> one bubble cycle, then grant_id=3 at the next edge.
REQ-031 SHALL pass: rst_n pulsed low mid-burst -> fifo_wr, req_ready and grant_valid at 0 immediately; after release, requester 0 wins first if valid.
REQ-032 SHALL pass: connected to FIFO_Memory (depth 16) with 4 requesters x 5 beats and a reader draining 1 beat per 2 cycles -> 20 beats read, fifo_overflow never set, per-requester order intact.
